// File: rtl/player_shot.sv
// Player projectile launcher: spawns a shot above the player, moves it upward, retires it at the top or on hit.
// Optional macro AUTOFIRE_EN: fire held high relaunches once per flight+cooldown period instead of edge-only.
module player_shot #(
   parameter int SPEED     = 4,
   parameter int MOVE_DIV  = 2,
   parameter int SPAWN_OFS = 10,
   parameter int COOLDOWN  = 64
) (
   input  logic        dclk,
   input  logic        clr,
   input  logic        play,
   input  logic        fire,
   input  logic        hit,
   input  logic [9:0]  player_x,
   input  logic [9:0]  player_y,
   output logic [9:0]  projectiles_x,
   output logic [9:0]  projectiles_y,
   output logic        active,
   output logic [13:0] shots_fired
);

   // state    | meaning
   // S_IDLE   | no shot, waiting for a fire trigger
   // S_FLIGHT | shot moving up the screen
   // S_COOL   | shot retired, counting down before the next launch
   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_FLIGHT = 2'd1,
      S_COOL   = 2'd2
   } state_t;

   localparam int MW = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
   localparam int CW = $clog2(COOLDOWN + 1);

   localparam logic [9:0]    SPEED_V   = 10'(SPEED);
   localparam logic [9:0]    SPAWN_V   = 10'(SPAWN_OFS);
   localparam logic [9:0]    MIN_Y     = 10'(SPAWN_OFS + SPEED);
   localparam logic [MW-1:0] MOVE_LAST = MW'(MOVE_DIV - 1);
   localparam logic [CW-1:0] COOL_LAST = CW'(COOLDOWN - 1);

   state_t        state_q, state_d;
   logic [9:0]    x_q, x_d;
   logic [9:0]    y_q, y_d;
   logic          active_q, active_d;
   logic [13:0]   shots_q, shots_d;
   logic [MW-1:0] move_q, move_d;
   logic [CW-1:0] cool_q, cool_d;
   logic          fire_q, fire_d;

   logic trig;
   logic launch;
   logic tick;
   logic retire;

   always_comb begin
`ifdef AUTOFIRE_EN
      trig = fire;
`else
      trig = fire & ~fire_q;
`endif
      launch = (state_q == S_IDLE) && trig && (player_y >= MIN_Y);
      tick   = (move_q == MOVE_LAST);
      // hit wins over a coincident move tick; the top-edge guard keeps y from underflowing
      retire = (state_q == S_FLIGHT) && (hit || (tick && (y_q <= SPEED_V)));
   end

   always_ff @(posedge dclk or posedge clr) begin
      if (clr) begin
         state_q  <= S_IDLE;
         x_q      <= '0;
         y_q      <= '0;
         active_q <= 1'b0;
         shots_q  <= '0;
         move_q   <= '0;
         cool_q   <= '0;
         fire_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         x_q      <= x_d;
         y_q      <= y_d;
         active_q <= active_d;
         shots_q  <= shots_d;
         move_q   <= move_d;
         cool_q   <= cool_d;
         fire_q   <= fire_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (!play) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE:   if (launch) state_d = S_FLIGHT;
            S_FLIGHT: if (retire) state_d = S_COOL;
            S_COOL:   if (cool_q == '0) state_d = S_IDLE;
            default:  state_d = S_IDLE;
         endcase
      end
   end

   always_comb begin
      x_d      = x_q;
      y_d      = y_q;
      active_d = active_q;
      shots_d  = shots_q;
      move_d   = move_q;
      cool_d   = cool_q;
      fire_d   = fire;
      if (!play) begin
         x_d      = '0;
         y_d      = '0;
         active_d = 1'b0;
         shots_d  = '0;
         move_d   = '0;
         cool_d   = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (launch) begin
                  x_d      = player_x;
                  y_d      = player_y - SPAWN_V;
                  active_d = 1'b1;
                  shots_d  = (shots_q == 14'h3FFF) ? shots_q : shots_q + 14'd1;
                  move_d   = '0;
               end
            end
            S_FLIGHT: begin
               if (retire) begin
                  x_d      = '0;
                  y_d      = '0;
                  active_d = 1'b0;
                  move_d   = '0;
                  cool_d   = COOL_LAST;
               end else if (tick) begin
                  move_d = '0;
                  y_d    = y_q - SPEED_V;
               end else begin
                  move_d = move_q + MW'(1);
               end
            end
            S_COOL: begin
               if (cool_q != '0) cool_d = cool_q - CW'(1);
            end
            default: ;
         endcase
      end
   end

   assign projectiles_x = x_q;
   assign projectiles_y = y_q;
   assign active        = active_q;
   assign shots_fired   = shots_q;

endmodule

// File: tb/tb_player_shot.sv
// Directed bench for player_shot: launch, flight, hit, cooldown, play/clr clearing and held fire.
module tb_player_shot;

   logic        dclk;
   logic        clr;
   logic        play;
   logic        fire;
   logic        hit;
   logic [9:0]  player_x;
   logic [9:0]  player_y;
   logic [9:0]  projectiles_x;
   logic [9:0]  projectiles_y;
   logic        active;
   logic [13:0] shots_fired;

   int tests_run;
   int tests_failed;

   player_shot dut (
      .dclk          (dclk),
      .clr           (clr),
      .play          (play),
      .fire          (fire),
      .hit           (hit),
      .player_x      (player_x),
      .player_y      (player_y),
      .projectiles_x (projectiles_x),
      .projectiles_y (projectiles_y),
      .active        (active),
      .shots_fired   (shots_fired)
   );

   initial dclk = 1'b0;
   always #5 dclk = ~dclk;

   task automatic cyc(input int n);
      repeat (n) @(negedge dclk);
   endtask

   task automatic pulse_fire();
      fire = 1'b1;
      cyc(1);
      fire = 1'b0;
   endtask

   task automatic test_reset();
      clr = 1'b1; play = 1'b0; fire = 1'b0; hit = 1'b0;
      player_x = 10'd300; player_y = 10'd400;
      cyc(3);
      tests_run++;
      if ({projectiles_x, projectiles_y, active, shots_fired} !== 35'd0) begin
         tests_failed++;
         $display("FAIL reset_outputs: got x=%0d y=%0d act=%0b shots=%0d, expected all 0",
                  projectiles_x, projectiles_y, active, shots_fired);
      end
      clr = 1'b0;
      play = 1'b1;
      cyc(2);
   endtask

   task automatic test_launch();
      pulse_fire();
      tests_run++;
      if (projectiles_x !== 10'd300 || projectiles_y !== 10'd390) begin
         tests_failed++;
         $display("FAIL launch_pos: got (%0d,%0d), expected (300,390)", projectiles_x, projectiles_y);
      end
      tests_run++;
      if (active !== 1'b1 || shots_fired !== 14'd1) begin
         tests_failed++;
         $display("FAIL launch_flags: got act=%0b shots=%0d, expected act=1 shots=1", active, shots_fired);
      end
      cyc(2);
      tests_run++;
      if (projectiles_y !== 10'd386) begin
         tests_failed++;
         $display("FAIL first_move: got y=%0d, expected 386", projectiles_y);
      end
   endtask

   // continues the shot from test_launch, two cycles after launch
   task automatic test_flight_to_top();
      bit found;
      bit step_bad;
      pulse_fire();
      tests_run++;
      if (shots_fired !== 14'd1 || projectiles_x !== 10'd300) begin
         tests_failed++;
         $display("FAIL press_in_flight: got shots=%0d x=%0d, expected shots=1 x=300", shots_fired, projectiles_x);
      end
      found = 1'b0;
      step_bad = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (projectiles_y == 10'd2) begin
            found = 1'b1;
            break;
         end
         if (projectiles_y[1:0] != 2'd2 || projectiles_x != 10'd300) step_bad = 1'b1;
         cyc(1);
      end
      tests_run++;
      if (!found || step_bad) begin
         tests_failed++;
         $display("FAIL reach_top: got found=%0b step_bad=%0b y=%0d, expected found=1 step_bad=0 y=2",
                  found, step_bad, projectiles_y);
      end
      cyc(1);
      tests_run++;
      if (projectiles_y !== 10'd2 || active !== 1'b1) begin
         tests_failed++;
         $display("FAIL top_hold: got y=%0d act=%0b, expected y=2 act=1", projectiles_y, active);
      end
      cyc(1);
      tests_run++;
      if ({projectiles_x, projectiles_y, active} !== 21'd0) begin
         tests_failed++;
         $display("FAIL top_retire: got (%0d,%0d) act=%0b, expected (0,0) act=0",
                  projectiles_x, projectiles_y, active);
      end
      // retire edge R just passed; press sampled at R+59 (cooldown count 5)
      cyc(58);
      pulse_fire();
      cyc(1);
      tests_run++;
      if (shots_fired !== 14'd1 || active !== 1'b0) begin
         tests_failed++;
         $display("FAIL press_cool5: got shots=%0d act=%0b, expected shots=1 act=0", shots_fired, active);
      end
      // press sampled at R+64: still the last cooldown cycle
      cyc(3);
      pulse_fire();
      cyc(1);
      tests_run++;
      if (shots_fired !== 14'd1 || active !== 1'b0) begin
         tests_failed++;
         $display("FAIL press_cool_last: got shots=%0d act=%0b, expected shots=1 act=0", shots_fired, active);
      end
   endtask

   task automatic test_hit();
      player_y = 10'd214;
      pulse_fire();
      tests_run++;
      if (projectiles_y !== 10'd204 || shots_fired !== 14'd2) begin
         tests_failed++;
         $display("FAIL hit_launch: got y=%0d shots=%0d, expected y=204 shots=2", projectiles_y, shots_fired);
      end
      cyc(2);
      tests_run++;
      if (projectiles_y !== 10'd200) begin
         tests_failed++;
         $display("FAIL hit_pre: got y=%0d, expected 200", projectiles_y);
      end
      cyc(1);
      hit = 1'b1;
      cyc(1);
      hit = 1'b0;
      tests_run++;
      if ({projectiles_x, projectiles_y, active} !== 21'd0) begin
         tests_failed++;
         $display("FAIL hit_retire: got (%0d,%0d) act=%0b, expected (0,0) act=0",
                  projectiles_x, projectiles_y, active);
      end
      // hit during cooldown must do nothing; first IDLE-cycle press at R+65 launches
      hit = 1'b1;
      cyc(1);
      hit = 1'b0;
      cyc(63);
      pulse_fire();
      tests_run++;
      if (active !== 1'b1 || shots_fired !== 14'd3 || projectiles_y !== 10'd204) begin
         tests_failed++;
         $display("FAIL relaunch_after_cool: got act=%0b shots=%0d y=%0d, expected act=1 shots=3 y=204",
                  active, shots_fired, projectiles_y);
      end
   endtask

   task automatic test_play_clear();
      cyc(3);
      play = 1'b0;
      fire = 1'b1;
      hit = 1'b1;
      cyc(1);
      fire = 1'b0;
      hit = 1'b0;
      tests_run++;
      if ({projectiles_x, projectiles_y, active, shots_fired} !== 35'd0) begin
         tests_failed++;
         $display("FAIL play_off: got (%0d,%0d) act=%0b shots=%0d, expected all 0",
                  projectiles_x, projectiles_y, active, shots_fired);
      end
      play = 1'b1;
      cyc(1);
      pulse_fire();
      tests_run++;
      if (active !== 1'b1 || shots_fired !== 14'd1) begin
         tests_failed++;
         $display("FAIL play_resume: got act=%0b shots=%0d, expected act=1 shots=1", active, shots_fired);
      end
      cyc(3);
      #2 clr = 1'b1;
      #1;
      tests_run++;
      if ({projectiles_x, projectiles_y, active, shots_fired} !== 35'd0) begin
         tests_failed++;
         $display("FAIL clr_async: got (%0d,%0d) act=%0b shots=%0d, expected all 0",
                  projectiles_x, projectiles_y, active, shots_fired);
      end
      cyc(1);
      clr = 1'b0;
      cyc(1);
   endtask

   task automatic test_low_player();
      player_y = 10'd12;
      pulse_fire();
      cyc(1);
      player_y = 10'd13;
      pulse_fire();
      tests_run++;
      if (active !== 1'b0 || shots_fired !== 14'd0) begin
         tests_failed++;
         $display("FAIL low_player: got act=%0b shots=%0d, expected act=0 shots=0", active, shots_fired);
      end
      cyc(1);
      player_y = 10'd14;
      pulse_fire();
      tests_run++;
      if (active !== 1'b1 || projectiles_y !== 10'd4) begin
         tests_failed++;
         $display("FAIL min_launch: got act=%0b y=%0d, expected act=1 y=4", active, projectiles_y);
      end
      cyc(2);
      tests_run++;
      if (active !== 1'b0 || projectiles_y !== 10'd0) begin
         tests_failed++;
         $display("FAIL min_retire: got act=%0b y=%0d, expected act=0 y=0", active, projectiles_y);
      end
   endtask

   task automatic test_hold_fire();
      logic [13:0] exp_shots;
      play = 1'b0;
      cyc(1);
      play = 1'b1;
      player_y = 10'd400;
      cyc(1);
      fire = 1'b1;
      cyc(300);
      fire = 1'b0;
`ifdef AUTOFIRE_EN
      exp_shots = 14'd2;
`else
      exp_shots = 14'd1;
`endif
      tests_run++;
      if (shots_fired !== exp_shots) begin
         tests_failed++;
         $display("FAIL hold_fire: got shots=%0d, expected %0d", shots_fired, exp_shots);
      end
   endtask

   initial begin
      tests_run = 0;
      tests_failed = 0;
      test_reset();
      test_launch();
      test_flight_to_top();
      test_hit();
      test_play_clear();
      test_low_player();
      test_hold_fire();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
